// File: rtl/fft_pkg.sv
// fft_pkg: shared types and defaults for the FFT stage sequencer.
`default_nettype none
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD_P = 2'd0,
    BFLY_P = 2'd1,
    LOAD_N = 2'd2,
    BFLY_N = 2'd3
  } shift_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int FRAME_BEATS_DEF = 32;

endpackage
`default_nettype wire

// File: rtl/fft_seq_pipe.sv
// fft_seq_pipe: two-stage delay line turning add_sub_en into mul_en/tw_idx and out_valid/frame_done.
`default_nettype none
module fft_seq_pipe #(
  parameter int TW_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            add_sub_en,
  input  logic [TW_W-1:0] tw_in,
  input  logic            done_in,
  output logic            mul_en,
  output logic [TW_W-1:0] tw_idx,
  output logic            out_valid,
  output logic            frame_done
);

  logic done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_en     <= 1'b0;
      tw_idx     <= '0;
      out_valid  <= 1'b0;
      done_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      mul_en     <= add_sub_en;
      // twiddle index only advances with a real butterfly beat, so it holds across gaps
      if (add_sub_en) tw_idx <= tw_in;
      out_valid  <= mul_en;
      done_d     <= done_in;
      frame_done <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fft_stage_seq.sv
// fft_stage_seq: beat sequencer for one radix-2 FFT stage (shift_type, strobes, twiddle index, framing).
// Optional macro FFT_SEQ_GAP_CHECK_EN: a mid-frame valid gap raises err_gap and aborts the frame.
`default_nettype none
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int HALF        = 8,
  parameter int FRAME_BEATS = FRAME_BEATS_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  output logic [1:0]              shift_type,
  output logic                    add_sub_en,
  output logic                    mul_en,
  output logic [$clog2(HALF)-1:0] tw_idx,
  output logic                    out_valid,
  output logic                    frame_start,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    err_gap
);

  localparam int LH = $clog2(HALF);
  localparam int CW = $clog2(FRAME_BEATS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);

  state_t        state;
  shift_t        phase;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_next;
  logic          done_in;

  // beat_cnt always names the beat presented this cycle, so the decode lines up with its data
  assign phase       = shift_t'(beat_cnt[LH+1:LH]);
  assign shift_type  = phase;
  assign add_sub_en  = valid & ((phase == BFLY_P) | (phase == BFLY_N));
  assign frame_start = rst & valid & (beat_cnt == '0);
  assign done_in     = add_sub_en & (beat_cnt == LAST);
  assign beat_next   = (beat_cnt == LAST) ? '0 : beat_cnt + CW'(1);
  assign busy        = (state != IDLE) | mul_en | out_valid;

`ifdef FFT_SEQ_GAP_CHECK_EN
  logic gap_flag;
  assign err_gap = gap_flag;
`else
  assign err_gap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
`ifdef FFT_SEQ_GAP_CHECK_EN
      gap_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state    <= RUN;
            beat_cnt <= beat_next;
          end
        end
        RUN: begin
          if (valid) begin
            beat_cnt <= beat_next;
          end else if (beat_cnt == '0) begin
            state <= FLUSH;
          end else begin
`ifdef FFT_SEQ_GAP_CHECK_EN
            gap_flag <= 1'b1;
            state    <= FLUSH;
            beat_cnt <= '0;
`endif
          end
        end
        FLUSH: begin
          // a new frame may start while the last butterflies are still draining
          if (valid) begin
            state    <= RUN;
            beat_cnt <= beat_next;
          end else if (!mul_en) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_seq_pipe #(
    .TW_W (LH)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .add_sub_en (add_sub_en),
    .tw_in      (beat_cnt[LH-1:0]),
    .done_in    (done_in),
    .mul_en     (mul_en),
    .tw_idx     (tw_idx),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_seq.sv
// tb_fft_stage_seq: checks fft_stage_seq (HALF=8 and HALF=4) against a frame-position model.
`default_nettype none
module tb_fft_stage_seq;

  localparam int FB = 32;
  localparam int NC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] st [2];
  logic       as [2];
  logic       me [2];
  logic       ov [2];
  logic       fs [2];
  logic       fd [2];
  logic       bz [2];
  logic       eg [2];
  logic [2:0] tw0;
  logic [1:0] tw1;

  fft_stage_seq #(.HALF(8), .FRAME_BEATS(FB)) dut0 (
    .clk(clk), .rst(rst), .valid(valid), .shift_type(st[0]), .add_sub_en(as[0]),
    .mul_en(me[0]), .tw_idx(tw0), .out_valid(ov[0]), .frame_start(fs[0]),
    .frame_done(fd[0]), .busy(bz[0]), .err_gap(eg[0])
  );

  fft_stage_seq #(.HALF(4), .FRAME_BEATS(FB)) dut1 (
    .clk(clk), .rst(rst), .valid(valid), .shift_type(st[1]), .add_sub_en(as[1]),
    .mul_en(me[1]), .tw_idx(tw1), .out_valid(ov[1]), .frame_start(fs[1]),
    .frame_done(fd[1]), .busy(bz[1]), .err_gap(eg[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: position of the next beat within its frame, plus a per-cycle log of butterfly beats.
  int  halfs [2] = '{8, 4};
  int  pos   [2] = '{0, 0};
  bit  err_m [2] = '{0, 0};
  bit  abort_m [2] = '{0, 0};
  bit  asub_at [2][NC];
  int  tw_at   [2][NC];
  bit  last_at [2][NC];
  int  cyc = 2;

  int ov_cnt [2];
  int fd_cnt [2];
  int fs_cnt [2];
  int as_cnt [2];
  int first_ov0 = -1;
  int fd_cyc0 = -1;
  int start0 = -1;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int h, ph, e_as, e_fs, e_mul, e_ov, e_fd, e_bz, tw_a;
      tw_a = (k == 0) ? int'(tw0) : int'(tw1);
      if (!rst) begin
        check($sformatf("rst_shift_type[%0d]", k), int'(st[k]), 0);
        check($sformatf("rst_add_sub_en[%0d]", k), int'(as[k]), 0);
        check($sformatf("rst_mul_en[%0d]", k), int'(me[k]), 0);
        check($sformatf("rst_tw_idx[%0d]", k), tw_a, 0);
        check($sformatf("rst_out_valid[%0d]", k), int'(ov[k]), 0);
        check($sformatf("rst_frame_start[%0d]", k), int'(fs[k]), 0);
        check($sformatf("rst_frame_done[%0d]", k), int'(fd[k]), 0);
        check($sformatf("rst_busy[%0d]", k), int'(bz[k]), 0);
        check($sformatf("rst_err_gap[%0d]", k), int'(eg[k]), 0);
        pos[k] = 0;
        err_m[k] = 1'b0;
        abort_m[k] = 1'b0;
        asub_at[k][cyc] = 1'b0;
        asub_at[k][cyc-1] = 1'b0;
      end else begin
        h     = halfs[k];
        ph    = (pos[k] / h) % 4;
        e_as  = (valid && (ph % 2 == 1)) ? 1 : 0;
        e_fs  = (valid && pos[k] == 0) ? 1 : 0;
        e_mul = int'(asub_at[k][cyc-1]);
        e_ov  = int'(asub_at[k][cyc-2]);
        e_fd  = (e_ov == 1 && last_at[k][cyc-2]) ? 1 : 0;
        e_bz  = (pos[k] != 0 || e_mul == 1 || e_ov == 1 || abort_m[k]) ? 1 : 0;
        check($sformatf("shift_type[%0d]", k), int'(st[k]), ph);
        check($sformatf("add_sub_en[%0d]", k), int'(as[k]), e_as);
        check($sformatf("mul_en[%0d]", k), int'(me[k]), e_mul);
        if (e_mul == 1) check($sformatf("tw_idx[%0d]", k), tw_a, tw_at[k][cyc-1]);
        check($sformatf("out_valid[%0d]", k), int'(ov[k]), e_ov);
        check($sformatf("frame_start[%0d]", k), int'(fs[k]), e_fs);
        check($sformatf("frame_done[%0d]", k), int'(fd[k]), e_fd);
        check($sformatf("busy[%0d]", k), int'(bz[k]), e_bz);
        check($sformatf("err_gap[%0d]", k), int'(eg[k]), int'(err_m[k]));
        asub_at[k][cyc] = e_as[0];
        tw_at[k][cyc]   = pos[k] % h;
        last_at[k][cyc] = (pos[k] == FB - 1);
        if (k == 0 && e_fs == 1 && start0 < 0) start0 = cyc;
        abort_m[k] = 1'b0;
        if (valid) pos[k] = (pos[k] + 1) % FB;
`ifdef FFT_SEQ_GAP_CHECK_EN
        else if (pos[k] != 0) begin
          err_m[k] = 1'b1;
          pos[k] = 0;
          abort_m[k] = 1'b1;
        end
`endif
        if (ov[k]) ov_cnt[k]++;
        if (fd[k]) fd_cnt[k]++;
        if (fs[k]) fs_cnt[k]++;
        if (as[k]) as_cnt[k]++;
        if (k == 0 && ov[0] && first_ov0 < 0) first_ov0 = cyc;
        if (k == 0 && fd[0]) fd_cyc0 = cyc;
      end
    end
    cyc++;
  end

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      valid = v;
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      ov_cnt[k] = 0; fd_cnt[k] = 0; fs_cnt[k] = 0; as_cnt[k] = 0;
    end
    first_ov0 = -1;
    fd_cyc0 = -1;
    start0 = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_counts();
    drive(0, 3);
    @(posedge clk); #1; rst = 1'b1;
    drive(0, 2);

    // single frame: latency and pulse counts
    clear_counts();
    drive(1, 32);
    drive(0, 6);
    check("f1_ov_count_h8", ov_cnt[0], 16);
    check("f1_ov_count_h4", ov_cnt[1], 16);
    check("f1_addsub_count_h8", as_cnt[0], 16);
    check("f1_first_ov_latency", first_ov0 - start0, 10);
    check("f1_frame_done_cycle", fd_cyc0 - start0, 33);
    check("f1_frame_done_count", fd_cnt[0], 1);

    // two frames back to back, then a third starting during FLUSH
    clear_counts();
    drive(1, 64);
    drive(0, 1);
    drive(1, 3);
    check("f2_ov_count_h8", ov_cnt[0], 32);
    check("f2_ov_count_h4", ov_cnt[1], 32);
    check("f2_frame_done_count", fd_cnt[0], 2);
    check("f2_frame_start_count", fs_cnt[0], 3);

    // gap at beat 12
    drive(1, 9);
`ifdef FFT_SEQ_GAP_CHECK_EN
    drive(0, 2);
    @(negedge clk);
    check("gap_err_set", int'(eg[0]), 1);
    drive(0, 1);
    drive(1, 1);
    @(negedge clk);
    check("gap_restart_shift", int'(st[0]), 0);
    check("gap_restart_fstart", int'(fs[0]), 1);
    drive(1, 1);
`else
    drive(0, 3);
    drive(1, 1);
    @(negedge clk);
    check("gap_resume_shift", int'(st[0]), 1);
    check("gap_resume_addsub", int'(as[0]), 1);
    drive(1, 1);
    @(negedge clk);
    check("gap_resume_tw", int'(tw0), 4);
    check("gap_resume_mul", int'(me[0]), 1);
`endif
    drive(1, 18);
    drive(0, 6);

    // reset mid-frame
    drive(1, 20);
    @(posedge clk); #1; rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", int'(bz[0]), 0);
    check("mid_rst_shift", int'(st[0]), 0);
    drive(0, 2);
    @(posedge clk); #1; rst = 1'b1; valid = 1'b1;
    @(negedge clk);
    check("post_rst_fstart", int'(fs[0]), 1);
    check("post_rst_shift", int'(st[0]), 0);
    drive(1, 31);
    drive(0, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_stage_seq.md
FFT_STAGE_SEQ -- requirements
Module: fft_stage_seq

Interface
REQ-001 SHALL have parameter HALF, default 8, meaning butterfly distance in beats (power of two, 2..16).
REQ-002 SHALL have parameter FRAME_BEATS, default 32, meaning beats per frame (multiple of 4*HALF).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port valid, input, 1, an input beat of 16 samples is present this cycle.
REQ-006 SHALL have port shift_type, output, 2, the datapath mux/op select: 0 LOAD_P, 1 BFLY_P, 2 LOAD_N, 3 BFLY_N.
REQ-007 SHALL have port add_sub_en, output, 1, the add/sub register-load strobe.
REQ-008 SHALL have port mul_en, output, 1, the twiddle-multiply register-load strobe.
REQ-009 SHALL have port tw_idx, output, $clog2(HALF), the twiddle index for the current mul_en beat.
REQ-010 SHALL have port out_valid, output, 1, the rounded butterfly outputs are valid.
REQ-011 SHALL have port frame_start, output, 1, a pulse on the first accepted beat of a frame.
REQ-012 SHALL have port frame_done, output, 1, a pulse coincident with the last out_valid of a frame.
REQ-013 SHALL have port busy, output, 1, meaning state is not IDLE or the pipeline is not empty.
REQ-014 SHALL have port err_gap, output, 1, a sticky flag for a valid gap inside a frame.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-016 IDLE->RUN SHALL occur on valid=1, and that beat is beat 0.
REQ-017 In RUN, beat_cnt SHALL increment on each valid beat, wrapping 0..FRAME_BEATS-1.
REQ-018 shift_type SHALL equal beat_cnt[log2(HALF)+1 : log2(HALF)], combinational from the registered counter, and SHALL be aligned with the current beat's data.
REQ-019 add_sub_en SHALL equal valid AND shift_type odd, in the same cycle as the beat.
REQ-020 mul_en SHALL equal add_sub_en delayed 1 cycle.
REQ-021 tw_idx SHALL equal beat_cnt[log2(HALF)-1:0] registered with add_sub_en.
REQ-022 out_valid SHALL equal mul_en delayed 1 cycle, giving a total latency of 2 cycles from the BFLY beat to out_valid.
REQ-023 When the last beat is accepted and valid=1 the next cycle, the FSM SHALL stay in RUN with beat_cnt=0 (back-to-back frames, no bubble) and pulse frame_start.
REQ-024 When the last beat is accepted and valid=0 the next cycle, the FSM SHALL go RUN->FLUSH and then FLUSH->IDLE once mul_en and out_valid have drained (2 cycles).
REQ-025 A valid=1 arriving during FLUSH SHALL start a new frame (beat 0) while the pipeline continues draining.
REQ-026 frame_done SHALL assert on out_valid for the final BFLY_N beat of each frame, once per frame.
REQ-027 With HALF=8 and FRAME_BEATS=32, each frame SHALL produce 16 add_sub_en, 16 mul_en and 16 out_valid pulses.

Reset
REQ-028 rst low SHALL asynchronously set state=IDLE, beat_cnt=0, and mul_en, tw_idx, out_valid, frame_start, frame_done, err_gap all 0.
REQ-029 While rst is low, shift_type SHALL be 0 and add_sub_en SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; the first valid after release SHALL be beat 0.

Configuration
REQ-031 Macro FFT_SEQ_GAP_CHECK_EN defined: valid=0 in RUN with beat_cnt!=0 SHALL set err_gap (sticky until reset), abort to FLUSH, and restart the next frame at beat 0.
REQ-032 Macro FFT_SEQ_GAP_CHECK_EN undefined: err_gap SHALL be tied 0, and a gap SHALL stall beat_cnt with add_sub_en=0 and shift_type held, then resume on the next valid.

Structure
REQ-033 A shared package fft_pkg SHALL hold the shift_type enum (LOAD_P, BFLY_P, LOAD_N, BFLY_N), the FSM state enum, and the FRAME_BEATS default constant.
REQ-034 A sub-module fft_seq_pipe SHALL implement the 2-stage enable/tw_idx/done delay line, instantiated once.

Verification
REQ-035 Reset, then 32 contiguous valid beats -> shift_type sequence 0x8,1x8,2x8,3x8; out_valid at cycles 10-17 and 26-33 after beat 0; frame_done at cycle 33; tw_idx 0..7 twice.
REQ-036 Two frames back-to-back (64 valid beats) -> frame_start at beats 0 and 32, beat_cnt wraps with no bubble, 32 out_valid, 2 frame_done.
REQ-037 With the macro on, valid=0 at beat 12 -> err_gap=1 the next cycle, state passes FLUSH->IDLE, and the following frame restarts at shift_type 0.
REQ-038 With the macro off, a 3-cycle gap at beat 12 -> add_sub_en=0 for 3 cycles, then beat 12 resumes as BFLY_P with tw_idx=4.
REQ-039 rst pulsed low at beat 20 -> all outputs are 0 immediately; the next valid gives frame_start=1 and shift_type=0.
REQ-040 Parameter override HALF=4 -> shift_type changes every 4 beats, tw_idx 0..3, and 16 out_valid pulses per 32-beat frame.
